// File: rtl/mem_ctrl.sv
// Byte-wide RAM/IO controller shared by fetch, load buffer and store buffer.
// Arbitrates, sequences multi-byte accesses and assembles read data.
module mem_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int IO_SEL_HI  = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear_all,
    input  logic                  io_buffer_full,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  lb_req,
    input  logic [ADDR_WIDTH-1:0] lb_addr,
    input  logic [1:0]            lb_size,
    input  logic                  lb_signed,
    output logic                  lb_done,
    output logic [31:0]           lb_data,
    input  logic                  sb_req,
    input  logic [ADDR_WIDTH-1:0] sb_addr,
    input  logic [1:0]            sb_size,
    input  logic [31:0]           sb_data,
    output logic                  sb_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [2:0]            cnt, cnt_nx;
    logic [2:0]            len, len_nx;
    logic                  sgn, sgn_nx;
    logic                  own_lb, own_lb_nx;
    logic [31:0]           rbuf, rbuf_nx;
    logic [ADDR_WIDTH-1:0] mem_a_nx;
    logic [7:0]            mem_dout_nx;
    logic                  mem_wr_nx;
    logic                  if_done_nx, lb_done_nx, sb_done_nx;
    logic [31:0]           if_data_nx, lb_data_nx;

    logic        sb_io, sb_ok, lb_ok, if_ok;
    logic        rd_last, wr_last;
    logic [1:0]  bidx, wnext;
    logic [31:0] rfull, rext;
    logic [7:0]  wbyte;

    function automatic logic [2:0] size_len(input logic [1:0] s);
        unique case (s)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // A requester whose done is showing has already been served.
    assign sb_io = (sb_addr[IO_SEL_HI:IO_SEL_HI-1] == 2'b11);
    assign sb_ok = sb_req && !sb_done && !(sb_io && io_buffer_full);
    assign lb_ok = lb_req && !lb_done && !clear_all;
    assign if_ok = if_req && !if_done && !clear_all;

    assign rd_last = (cnt == len);
    assign wr_last = (cnt == len - 3'd1);

    // In READ, mem_din carries byte cnt-1.
    assign bidx  = cnt[1:0] - 2'd1;
    assign wnext = cnt[1:0] + 2'd1;
    assign wbyte = sb_data[{wnext, 3'b000} +: 8];

    always_comb begin
        rfull = rbuf;
        rfull[{bidx, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        rext = rfull;
        if (len == 3'd1) begin
            rext = {{24{sgn & rfull[7]}}, rfull[7:0]};
        end else if (len == 3'd2) begin
            rext = {{16{sgn & rfull[15]}}, rfull[15:0]};
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else if (rdy_in) begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (sb_ok) begin
                    state_nx = WRITE;
                end else if (lb_ok || if_ok) begin
                    state_nx = READ;
                end
            end
            READ: begin
                if (clear_all || rd_last) begin
                    state_nx = IDLE;
                end
            end
            WRITE: begin
                if (wr_last) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_a_nx    = mem_a;
        mem_dout_nx = mem_dout;
        mem_wr_nx   = mem_wr;
        if_done_nx  = 1'b0;
        lb_done_nx  = 1'b0;
        sb_done_nx  = 1'b0;
        if_data_nx  = if_data;
        lb_data_nx  = lb_data;
        cnt_nx      = cnt;
        len_nx      = len;
        sgn_nx      = sgn;
        own_lb_nx   = own_lb;
        rbuf_nx     = rbuf;
        unique case (state)
            IDLE: begin
                cnt_nx    = 3'd0;
                mem_wr_nx = 1'b0;
                if (sb_ok) begin
                    mem_a_nx    = sb_addr;
                    mem_dout_nx = sb_data[7:0];
                    mem_wr_nx   = 1'b1;
                    len_nx      = size_len(sb_size);
                    sgn_nx      = 1'b0;
                    own_lb_nx   = 1'b0;
                end else if (lb_ok) begin
                    mem_a_nx  = lb_addr;
                    len_nx    = size_len(lb_size);
                    sgn_nx    = lb_signed;
                    own_lb_nx = 1'b1;
                end else if (if_ok) begin
                    mem_a_nx  = if_addr;
                    len_nx    = 3'd4;
                    sgn_nx    = 1'b0;
                    own_lb_nx = 1'b0;
                end
            end
            READ: begin
                mem_wr_nx = 1'b0;
                if (!clear_all) begin
                    if (cnt != 3'd0) begin
                        rbuf_nx = rfull;
                    end
                    if (rd_last) begin
                        if (own_lb) begin
                            lb_data_nx = rext;
                            lb_done_nx = 1'b1;
                        end else begin
                            if_data_nx = rext;
                            if_done_nx = 1'b1;
                        end
                    end else begin
                        cnt_nx = cnt + 3'd1;
                        if (cnt + 3'd1 < len) begin
                            mem_a_nx = mem_a + ADDR_WIDTH'(1);
                        end
                    end
                end
            end
            WRITE: begin
                if (wr_last) begin
                    mem_wr_nx  = 1'b0;
                    sb_done_nx = 1'b1;
                end else begin
                    cnt_nx      = cnt + 3'd1;
                    mem_a_nx    = mem_a + ADDR_WIDTH'(1);
                    mem_dout_nx = wbyte;
                end
            end
            default: mem_wr_nx = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_a    <= '0;
            mem_dout <= 8'd0;
            mem_wr   <= 1'b0;
            if_done  <= 1'b0;
            lb_done  <= 1'b0;
            sb_done  <= 1'b0;
            if_data  <= 32'd0;
            lb_data  <= 32'd0;
            cnt      <= 3'd0;
            len      <= 3'd0;
            sgn      <= 1'b0;
            own_lb   <= 1'b0;
            rbuf     <= 32'd0;
        end else if (rdy_in) begin
            mem_a    <= mem_a_nx;
            mem_dout <= mem_dout_nx;
            mem_wr   <= mem_wr_nx;
            if_done  <= if_done_nx;
            lb_done  <= lb_done_nx;
            sb_done  <= sb_done_nx;
            if_data  <= if_data_nx;
            lb_data  <= lb_data_nx;
            cnt      <= cnt_nx;
            len      <= len_nx;
            sgn      <= sgn_nx;
            own_lb   <= own_lb_nx;
            rbuf     <= rbuf_nx;
        end
    end

endmodule
